// File: rtl/intercal_alu_host_pkg.sv
// intercal_alu_host_pkg
// Shared types and constants for the INTERCAL ALU host sequencer.
//   - state_t      : sequencer state encoding
//   - UI_* fields  : bit positions inside the ALU's ui_in byte
//   - WR_BYTES / RD_BYTES : operand bytes written, result bytes read
//   - first_set, ui_write, ui_read : pin-encoding helpers
package intercal_alu_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_SETTLE,
    ST_DONE
  } state_t;

  // ui_in bit assignments on the ALU chip
  localparam int UI_NLOAD   = 7;  // low opens the selected load latch
  localparam int UI_NDRIVE  = 6;  // high keeps the ALU off the uio bus
  localparam int UI_OP_MSB  = 5;
  localparam int UI_OP_LSB  = 2;
  localparam int UI_SEL_MSB = 1;
  localparam int UI_SEL_LSB = 0;

  localparam int WR_BYTES = 8;    // A bytes 0-3, then B bytes 0-3
  localparam int RD_BYTES = 4;

  // Quiescent pin value: latches closed, ALU not driving uio
  localparam logic [7:0] UI_IDLE = 8'hC0;

  // Lowest set bit of a byte-pending mask (0 when the mask is empty).
  function automatic logic [2:0] first_set(input logic [WR_BYTES-1:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = WR_BYTES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Latch-address encoding: opcode field must be zero for the load decode.
  function automatic logic [7:0] ui_write(input logic nload, input logic [2:0] idx);
    logic [7:0] v;
    v            = '0;
    v[UI_NLOAD]  = nload;
    v[UI_NDRIVE] = 1'b1;
    v[2:0]       = idx;
    return v;
  endfunction

  // Read encoding: opcode plus result-byte selector, latches closed.
  function automatic logic [7:0] ui_read(input logic [3:0] op, input logic [1:0] sel);
    logic [7:0] v;
    v                         = '0;
    v[UI_NLOAD]               = 1'b1;
    v[UI_NDRIVE]              = 1'b1;
    v[UI_OP_MSB:UI_OP_LSB]    = op;
    v[UI_SEL_MSB:UI_SEL_LSB]  = sel;
    return v;
  endfunction

endpackage

// File: rtl/intercal_alu_host_if.sv
// intercal_alu_host_if
// Bundles the 32-bit request/response port and the ALU chip pins.
//   slave  : view used by the host sequencer (takes requests, drives pins)
//   master : view used by the requester / board model
interface intercal_alu_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  alu_ui;
  logic [7:0]  alu_uio_out;
  logic        alu_uio_oe;
  logic [7:0]  alu_uo;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_uo,
    output req_ready, rsp_valid, rsp_data, alu_ui, alu_uio_out, alu_uio_oe
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_uo,
    input  req_ready, rsp_valid, rsp_data, alu_ui, alu_uio_out, alu_uio_oe
  );
endinterface

// File: rtl/intercal_alu_host_cache.sv
// intercal_alu_host_cache
// Shadow copy of the operand bytes last written into the ALU latches.
// Used only when INTERCAL_ALU_HOST_CACHE_EN is defined.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears valid bits)
//   ops_in    : candidate operands {B, A} of the incoming request
//   dirty     : per byte, 1 when the ALU latch must be (re)written
//   wr_en     : a byte write to the ALU has completed this cycle
//   wr_idx    : which latch was written (0-3 A, 4-7 B)
//   wr_byte   : value written
module intercal_alu_host_cache
  import intercal_alu_host_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*WR_BYTES-1:0] ops_in,
  output logic [WR_BYTES-1:0]   dirty,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [7:0]            wr_byte
);

  logic [7:0]          shadow_mem [WR_BYTES];
  logic [WR_BYTES-1:0] valid_reg;

  // Data needs no reset: a byte is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_mem[wr_idx] <= wr_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WR_BYTES; gi++) begin : g_cmp
      assign dirty[gi] = !valid_reg[gi] || (shadow_mem[gi] != ops_in[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: rtl/intercal_alu_host.sv
// intercal_alu_host
// Host-side sequencer for the INTERCAL ALU chip. Writes operands A and B
// byte by byte through the ALU's level-sensitive load latches (setup,
// strobe, hold per byte), then steps the result selector over four bytes,
// sampling each after SETTLE cycles, and returns the 32-bit result.
// Optional macro: INTERCAL_ALU_HOST_CACHE_EN -- skip rewriting operand
// bytes already held in the ALU latches.
// Parameters:
//   SETTLE : cycles each result selector is held before sampling (>= 1)
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : request/response port and ALU pins (slave view)
//          req_valid/req_ready/req_op/req_a/req_b, rsp_valid/rsp_ready/
//          rsp_data, alu_ui, alu_uio_out, alu_uio_oe, alu_uo
module intercal_alu_host
  import intercal_alu_host_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  intercal_alu_host_if.slave  bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_t                state_reg, state_next;
  logic [2:0]            k_reg, k_next;          // latch being written
  logic [1:0]            j_reg, j_next;          // result byte being read
  logic [CNT_W-1:0]      cnt_reg, cnt_next;      // settle counter
  logic [3:0]            op_reg, op_next;
  logic [8*WR_BYTES-1:0] ops_reg, ops_next;      // {B, A}
  logic [WR_BYTES-1:0]   pend_reg, pend_next;    // bytes still to write
  logic [31:0]           rsp_data_reg, rsp_data_next;
  logic [7:0]            ui_reg, ui_next;
  logic [7:0]            uio_reg, uio_next;
  logic                  oe_reg, oe_next;

  logic [8*WR_BYTES-1:0] req_ops;
  logic [WR_BYTES-1:0]   dirty_in;
  logic [WR_BYTES-1:0]   pend_rest;

  assign req_ops   = {bus.req_b, bus.req_a};
  assign pend_rest = pend_reg & ~(WR_BYTES'(1) << k_reg);

`ifdef INTERCAL_ALU_HOST_CACHE_EN
  logic       cache_wr_en;
  logic [7:0] cache_wr_byte;

  // A byte counts as written once its hold cycle completes.
  assign cache_wr_en   = (state_reg == ST_WR_HOLD);
  assign cache_wr_byte = ops_reg[8*k_reg +: 8];

  intercal_alu_host_cache u_cache (
    .clk     (clk),
    .rst     (rst),
    .ops_in  (req_ops),
    .dirty   (dirty_in),
    .wr_en   (cache_wr_en),
    .wr_idx  (k_reg),
    .wr_byte (cache_wr_byte)
  );
`else
  assign dirty_in = '1;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    j_next        = j_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    ops_next      = ops_reg;
    pend_next     = pend_reg;
    rsp_data_next = rsp_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_next  = bus.req_op;
          ops_next = req_ops;
          j_next   = '0;
          cnt_next = '0;
          if (|dirty_in) begin
            pend_next  = dirty_in;
            k_next     = first_set(dirty_in);
            state_next = ST_WR_SETUP;
          end else begin
            // Everything already latched in the ALU: go straight to reads
            pend_next  = '0;
            state_next = ST_RD_SETTLE;
          end
        end
      end
      ST_WR_SETUP:  state_next = ST_WR_STROBE;
      ST_WR_STROBE: state_next = ST_WR_HOLD;
      ST_WR_HOLD: begin
        pend_next = pend_rest;
        if (|pend_rest) begin
          k_next     = first_set(pend_rest);
          state_next = ST_WR_SETUP;
        end else begin
          j_next     = '0;
          cnt_next   = '0;
          state_next = ST_RD_SETTLE;
        end
      end
      ST_RD_SETTLE: begin
        if (cnt_reg == CNT_LAST) begin
          rsp_data_next[8*j_reg +: 8] = bus.alu_uo;
          cnt_next = '0;
          if (j_reg == 2'(RD_BYTES - 1)) begin
            state_next = ST_DONE;
          end else begin
            j_next = j_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin values for the coming state; registered so the latch enable
  // (ui[7]) never glitches on the way to the chip.
  always_comb begin
    ui_next  = UI_IDLE;
    uio_next = '0;
    oe_next  = 1'b0;
    case (state_next)
      ST_WR_SETUP, ST_WR_HOLD: begin
        ui_next  = ui_write(1'b1, k_next);
        uio_next = ops_next[8*k_next +: 8];
        oe_next  = 1'b1;
      end
      ST_WR_STROBE: begin
        ui_next  = ui_write(1'b0, k_next);
        uio_next = ops_next[8*k_next +: 8];
        oe_next  = 1'b1;
      end
      ST_RD_SETTLE: begin
        ui_next = ui_read(op_next, j_next);
      end
      default: begin
        ui_next = UI_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      j_reg        <= '0;
      cnt_reg      <= '0;
      op_reg       <= '0;
      ops_reg      <= '0;
      pend_reg     <= '0;
      rsp_data_reg <= '0;
      ui_reg       <= UI_IDLE;
      uio_reg      <= '0;
      oe_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      j_reg        <= j_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      ops_reg      <= ops_next;
      pend_reg     <= pend_next;
      rsp_data_reg <= rsp_data_next;
      ui_reg       <= ui_next;
      uio_reg      <= uio_next;
      oe_reg       <= oe_next;
    end
  end

  assign bus.req_ready   = (state_reg == ST_IDLE);
  assign bus.rsp_valid   = (state_reg == ST_DONE);
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.alu_ui      = ui_reg;
  assign bus.alu_uio_out = uio_reg;
  assign bus.alu_uio_oe  = oe_reg;

endmodule

// File: doc/intercal_alu_host.md
# intercal_alu_host

Host-side sequencer that drives the INTERCAL ALU chip's byte-wide pin interface from a 32-bit request/response port. It writes operands A and B byte by byte through the ALU's level-sensitive load latches, selects the opcode, reads back the four result bytes, and returns the assembled 32-bit result. It sits on the FPGA or test-board side, wired pin-for-pin to the ALU chip's `ui_in`, `uio_in` and `uo_out`.

## Interface
- `SETTLE`, default 2: cycles the read selector is held before each result byte is sampled; legal range ≥1.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 4: ALU opcode.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: result accepted.
- `rsp_data` out 32: assembled result.
- `alu_ui` out 8: drives the ALU's `ui_in`.
- `alu_uio_out` out 8: drives the ALU's `uio_in`.
- `alu_uio_oe` out 1: host output enable on the uio bus.
- `alu_uo` in 8: from the ALU's `uo_out`.

## Operation
- ALU pin encoding:
  - `ui[7]=0` with `ui[5:3]=0` opens the load latch selected by `ui[2:0]` (0–3 = A bytes 0–3, 4–7 = B bytes 0–3).
  - `ui[6]=1` keeps the ALU from driving uio.
  - `ui[5:2]` is the opcode.
  - `ui[1:0]` selects the result byte.
- `alu_ui[6]` is 1 at all times.
- States:
  - IDLE: accept on `req_valid && req_ready`; latch op, A and B; set byte index k=0; go to WR_SETUP.
  - WR_SETUP: `alu_ui={1,1,3'b0,k}`; `alu_uio_out`=operand byte k; `alu_uio_oe=1`.
  - WR_STROBE: same, but `alu_ui[7]=0`, so the latch is transparent.
  - WR_HOLD: `alu_ui[7]=1`, data unchanged, latch closed. Then k++; after k=7 go to RD_SETTLE with j=0.
  - RD_SETTLE: `alu_ui={1,1,op,j}`; `alu_uio_oe=0`. Hold for SETTLE cycles; at the edge ending the last cycle, sample `alu_uo` into `rsp_data[8j+:8]`. j++; after j=3 go to DONE.
  - DONE: `rsp_valid=1` until `rsp_ready`, then IDLE.
- Data and address are stable one cycle before and one cycle after every strobe cycle.
- `rsp_data` holds its value until the next sample overwrites it.

## Timing
- Reset values:
  - `alu_ui=8'hC0`, `alu_uio_out=0`, `alu_uio_oe=0`.
  - `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, state IDLE.
- Request accepted at edge T: write phase occupies T+1..T+24 (8 bytes × 3 cycles).
- Reads occupy 4×SETTLE cycles; `rsp_valid` rises at cycle T+25+4·SETTLE (T+33 at default).
- No new request is accepted in DONE, even in the cycle `rsp_ready` is high. Earliest next accept is one cycle after the response handshake.
- `req_*` inputs are don't-care outside the accept cycle.
- Reset mid-operation:
  - All outputs return to reset values immediately.
  - `alu_ui[7]=1` closes any open latch.
  - `alu_uio_oe` drops.
  - A partially written operand in the ALU is unspecified.

## Configuration
- `INTERCAL_ALU_HOST_CACHE_EN` defined:
  - Keep a 64-bit shadow of the last written A/B bytes plus 8 valid bits.
  - Skip the 3-cycle write of any byte whose valid bit is set and whose value matches.
  - Reset clears all valid bits.
  - Fully cached request: `rsp_valid` at T+1+4·SETTLE.
- Undefined: all 8 bytes are always written; no shadow storage.

## Structure
- Package `intercal_alu_host_pkg`:
  - state enum;
  - pin bit constants `UI_NLOAD=7`, `UI_NDRIVE=6`;
  - field positions for opcode (5:2) and select (1:0);
  - byte count constants (8 write, 4 read).
- One natural sub-module, `intercal_alu_host_cache`: shadow and compare, instantiated only under the macro.
- The FSM and counters stay in `intercal_alu_host`.

## Test plan
- Reset, then idle:
  - `alu_ui=C0`, `alu_uio_oe=0`, `req_ready=1`, `rsp_valid=0`.
  - Assert `rst` mid-write: outputs return to reset values in the same cycle.
- A=12345678, B=9ABCDEF0, op=3 (macro undefined):
  - uio bytes in order 78,56,34,12,F0,DE,BC,9A.
  - Strobe `alu_ui` values 40..47, each framed by C0+k before and after.
  - Read selectors CC,CD,CE,CF.
- Bench ALU model returns `{4'hA,op}` for byte 0 and `8'h11·(j+1)` for byte j>0:
  - `rsp_data=443322A3`.
  - `rsp_valid` exactly at T+33.
- Backpressure: hold `rsp_ready=0` for 10 cycles. `rsp_valid` and `rsp_data` stay stable and `req_ready=0` throughout; release leads to IDLE one cycle later.
- SETTLE=1 build: latency T+29, and each byte is sampled after exactly one selector cycle.
- Macro defined, same request issued twice:
  - Second request performs zero write strobes; `rsp_valid` at T+9.
  - Change only B byte 2 to 00: exactly one strobe, with `alu_ui=46` and uio=00.
  - After reset, all 8 bytes are written again.
